// File: rtl/note_tone_seq.sv
// note_tone_seq: accepts one note command at a time and plays it as a 50%-duty
// square wave for dur_ms ticks. The tone always ends on a falling half-period
// boundary, and done pulses for one cycle when the command completes.
module note_tone_seq #(
  parameter int TICK_DIV = 5000,
  parameter int CNT_W    = 14,
  parameter int DUR_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  input  logic [DUR_W-1:0] dur_ms,
  output logic             tone_out,
  output logic             playing,
  output logic             done,
  output logic [7:0]       note_leds
);

  localparam int TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state, state_nxt;
  logic [3:0]         note_q;
  logic [1:0]         oct_q;
  logic [CNT_W-1:0]   cnt;
  logic [TK_W-1:0]    tick_cnt;
  logic [DUR_W-1:0]   remaining;

  logic               accept;
  logic               is_rest;
  logic [CNT_W-1:0]   base;
  logic [CNT_W-1:0]   term;
  logic               cnt_hit;
  logic               expired;
  logic               tick_wrap;
  logic               end_now;

  // Base half-period per note at octave 0; rests get 0 (counter unused then).
  always_comb begin
    base = '0;
    case (note_q)
      4'd1:  base = CNT_W'(9560);
      4'd2:  base = CNT_W'(9025);
      4'd3:  base = CNT_W'(8518);
      4'd4:  base = CNT_W'(8039);
      4'd5:  base = CNT_W'(7587);
      4'd6:  base = CNT_W'(7163);
      4'd7:  base = CNT_W'(6766);
      4'd8:  base = CNT_W'(6378);
      4'd9:  base = CNT_W'(6017);
      4'd10: base = CNT_W'(5682);
      4'd11: base = CNT_W'(5364);
      4'd12: base = CNT_W'(5066);
      default: base = '0;
    endcase
  end

  // Derived terms: half-period terminal, expiry, and the glitch-free end test.
  always_comb begin
    is_rest   = (note_q == 4'd0) || (note_q > 4'd12);
    term      = base >> oct_q;
    cnt_hit   = (cnt == term);
    expired   = (remaining == '0);
    tick_wrap = (tick_cnt == TK_W'(TICK_DIV - 1));
    // Ending while high is only allowed on the edge that would toggle low anyway.
    end_now   = expired && (!tone_out || is_rest || cnt_hit);
    accept    = note_valid && note_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt  = state;
    note_ready = 1'b0;
    playing    = 1'b0;
    case (state)
      IDLE: begin
        note_ready = 1'b1;
        if (note_valid) state_nxt = PLAY;
      end
      PLAY: begin
        playing = 1'b1;
        if (end_now) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: command latch, tone counter, duration counter, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q    <= '0;
      oct_q     <= '0;
      cnt       <= '0;
      tick_cnt  <= '0;
      remaining <= '0;
      tone_out  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        note_q    <= note;
        oct_q     <= octave;
        remaining <= dur_ms;
        cnt       <= '0;
        tick_cnt  <= '0;
        tone_out  <= 1'b0;
      end else if (state == PLAY) begin
        // Half-period counter; idle and silent for rests.
        if (is_rest) begin
          cnt      <= '0;
          tone_out <= 1'b0;
        end else if (cnt_hit) begin
          cnt      <= '0;
          tone_out <= ~tone_out;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // Millisecond ticks; remaining saturates at zero.
        if (tick_wrap) begin
          tick_cnt <= '0;
          if (!expired) remaining <= remaining - 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        if (end_now) begin
          tone_out <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

  // LED pattern for the latched note while playing.
  always_comb begin
    note_leds = 8'h00;
    if (state == PLAY) begin
      case (note_q)
        4'd1:  note_leds = 8'h01;
        4'd2:  note_leds = 8'h03;
        4'd3:  note_leds = 8'h02;
        4'd4:  note_leds = 8'h06;
        4'd5:  note_leds = 8'h04;
        4'd6:  note_leds = 8'h08;
        4'd7:  note_leds = 8'h18;
        4'd8:  note_leds = 8'h10;
        4'd9:  note_leds = 8'h30;
        4'd10: note_leds = 8'h20;
        4'd11: note_leds = 8'h60;
        4'd12: note_leds = 8'h40;
        default: note_leds = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_seq.sv
// Directed bench for note_tone_seq with TICK_DIV=10. Durations are scaled so
// that the expiry edges match the 100- and 5000-cycle tick scenarios.
module tb_note_tone_seq;

  localparam int DUR_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             note_valid = 1'b0;
  logic             note_ready;
  logic [3:0]       note = '0;
  logic [1:0]       octave = '0;
  logic [DUR_W-1:0] dur_ms = '0;
  logic             tone_out;
  logic             playing;
  logic             done;
  logic [7:0]       note_leds;

  int checks = 0;
  int failures = 0;

  note_tone_seq #(.TICK_DIV(10), .CNT_W(14), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
    .note(note), .octave(octave), .dur_ms(dur_ms), .tone_out(tone_out),
    .playing(playing), .done(done), .note_leds(note_leds)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a command and let it be accepted on the next edge (E0).
  task automatic issue(input logic [3:0] n, input logic [1:0] o, input logic [DUR_W-1:0] d);
    note = n; octave = o; dur_ms = d; note_valid = 1'b1;
    cyc(1);
    note_valid = 1'b0;
  endtask

  // Measure rise delay and high/low phase lengths, then reset mid-tone.
  task automatic freq_test(input string tag, input logic [3:0] n, input logic [1:0] o,
                           input int half, input logic [7:0] leds);
    int c;
    issue(n, o, 12'd4095);
    chk({tag, "_leds"}, note_leds, leds);
    c = 0;
    while (tone_out !== 1'b1 && c < 20000) begin cyc(1); c++; end
    chk({tag, "_first_rise"}, c, half);
    c = 0;
    while (tone_out === 1'b1 && c < 20000) begin cyc(1); c++; end
    chk({tag, "_high"}, c, half);
    c = 0;
    while (tone_out !== 1'b1 && c < 20000) begin cyc(1); c++; end
    chk({tag, "_low"}, c, half);
    // Asynchronous reset while tone is high.
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_tone"}, tone_out, 1'b0);
    chk({tag, "_rst_play"}, playing, 1'b0);
    chk({tag, "_rst_leds"}, note_leds, 8'h00);
    #3;
    rst_n = 1'b1;
    cyc(1);
    chk({tag, "_rst_ready"}, note_ready, 1'b1);
    c = 0;
    repeat (5) begin
      if (done !== 1'b0) c++;
      cyc(1);
    end
    chk({tag, "_rst_no_done"}, c, 0);
  endtask

  task automatic rest_test(input string tag, input logic [3:0] n);
    int bad;
    issue(n, 2'd0, 12'd2);
    bad = 0;
    repeat (19) begin
      cyc(1);
      if (tone_out !== 1'b0 || note_leds !== 8'h00 || done !== 1'b0) bad++;
    end
    chk({tag, "_quiet"}, bad, 0);
    cyc(1);
    chk({tag, "_e20_done"}, done, 1'b0);
    cyc(1);
    chk({tag, "_e21_done"}, done, 1'b1);
    chk({tag, "_e21_ready"}, note_ready, 1'b1);
  endtask

  initial begin
    int bad;
    // Reset state.
    cyc(3);
    chk("rst_tone", tone_out, 1'b0);
    chk("rst_play", playing, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_leds", note_leds, 8'h00);
    chk("rst_ready", note_ready, 1'b1);
    rst_n = 1'b1;
    cyc(2);

    // A4, octave 0, 3 ticks: expires at E30, tone never toggles, done after E31.
    issue(4'd10, 2'd0, 12'd3);
    chk("a_play", playing, 1'b1);
    chk("a_ready", note_ready, 1'b0);
    chk("a_leds", note_leds, 8'h20);
    cyc(30);
    chk("a_e30_done", done, 1'b0);
    chk("a_e30_play", playing, 1'b1);
    chk("a_e30_tone", tone_out, 1'b0);
    cyc(1);
    chk("a_e31_done", done, 1'b1);
    chk("a_e31_play", playing, 1'b0);
    chk("a_e31_leds", note_leds, 8'h00);
    cyc(1);
    chk("a_e32_done", done, 1'b0);

    // A, octave 3 (term 710), expiry at E1000: rise E711, fall+end E1422.
    issue(4'd10, 2'd3, 12'd100);
    cyc(710);
    chk("b_e710_tone", tone_out, 1'b0);
    cyc(1);
    chk("b_e711_tone", tone_out, 1'b1);
    bad = 0;
    for (int k = 712; k <= 1421; k++) begin
      if (k == 800) begin
        // A command offered mid-PLAY must be ignored.
        note = 4'd1; octave = 2'd0; dur_ms = 12'd0; note_valid = 1'b1;
      end
      cyc(1);
      if (k == 800) begin
        note_valid = 1'b0;
        chk("b_ignore_play", playing, 1'b1);
        chk("b_ignore_leds", note_leds, 8'h20);
      end
      if (tone_out !== 1'b1 || done !== 1'b0 || playing !== 1'b1) bad++;
    end
    chk("b_hold_high", bad, 0);
    cyc(1);
    chk("b_e1422_tone", tone_out, 1'b0);
    chk("b_e1422_done", done, 1'b1);
    cyc(1);

    // Frequency checks, no expiry within the window.
    freq_test("c_oct1", 4'd1, 2'd1, 4781, 8'h01);
    freq_test("b_oct2", 4'd12, 2'd2, 1267, 8'h40);

    // Rests.
    rest_test("rest0", 4'd0);
    cyc(1);
    rest_test("rest14", 4'd14);
    cyc(1);

    // Zero duration: done right after E1.
    issue(4'd5, 2'd0, 12'd0);
    chk("z_play", playing, 1'b1);
    chk("z_leds", note_leds, 8'h04);
    cyc(1);
    chk("z_e1_done", done, 1'b1);
    chk("z_e1_tone", tone_out, 1'b0);
    cyc(2);

    // note_valid held high: next command taken on the edge after done rises.
    note = 4'd7; octave = 2'd0; dur_ms = 12'd1; note_valid = 1'b1;
    cyc(1);
    chk("bb_play", playing, 1'b1);
    cyc(10);
    chk("bb_e10_done", done, 1'b0);
    cyc(1);
    chk("bb_e11_done", done, 1'b1);
    chk("bb_e11_ready", note_ready, 1'b1);
    chk("bb_e11_play", playing, 1'b0);
    cyc(1);
    note_valid = 1'b0;
    chk("bb_e12_play", playing, 1'b1);
    chk("bb_e12_done", done, 1'b0);
    chk("bb_e12_leds", note_leds, 8'h18);
    cyc(11);
    chk("bb2_done", done, 1'b1);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
